dcache_miss_ctrl: RTL and testbench

Miss and write-through controller sitting directly below the 8-line direct-mapped data cache, between the cache and the multi-cycle backing data memory. Stalls the pipeline on load misses, fetches the missing word over a req/ack handshake, and drives the cache fill port. Stores are write-through/no-allocate via a small write buffer that drains in the background and is fully drained before any miss read.

---
 rtl/dcache_pkg.sv | 21 ++
 rtl/dcache_write_buffer.sv | 73 +++++++
 rtl/dcache_miss_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types for the data-cache miss / write-through controller.
// The write-buffer payload width sets the controller's DATA_WIDTH default.
package dcache_pkg;

    localparam int WB_DATA_W        = 32;
    localparam int WB_DEPTH_DEFAULT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_DRAIN,
        S_READ,
        S_FILL
    } state_t;

    typedef struct packed {
        logic [31:0]          addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/dcache_write_buffer.sv
// Store write buffer: small synchronous FIFO exposing the head entry and the
// one behind it, so the controller can launch the next write on the ack cycle.
module dcache_write_buffer
    import dcache_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  wb_entry_t                  i_entry,
    output wb_entry_t                  o_head,
    output wb_entry_t                  o_next,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;
    logic          w_wr_ok;
    logic          w_rd_ok;
    wb_entry_t     w_slots [DEPTH];

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // A push into a full buffer is accepted only when the head leaves the same cycle.
    assign w_wr_ok = i_push && (!o_full || i_pop);
    assign w_rd_ok = i_pop && !o_empty;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            wb_entry_t r_slot;
            always_ff @(posedge i_clk) begin
                if (w_wr_ok && (r_wr_ptr == PW'(gi))) begin
                    r_slot <= i_entry;
                end
            end
            assign w_slots[gi] = r_slot;
        end
    endgenerate

    assign o_head = w_slots[r_rd_ptr];
    assign o_next = w_slots[r_rd_ptr + PW'(1)];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Miss and write-through controller below the direct-mapped data cache:
// stalls on load misses, drains buffered stores, fetches and fills the word.
module dcache_miss_ctrl
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_W,
    parameter int WB_DEPTH   = WB_DEPTH_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_en_i,
    input  logic                  wr_en_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  hit_i,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rdata_valid_o,
    output logic                  fill_en_o,
    output logic [31:0]           fill_addr_o,
    output logic [DATA_WIDTH-1:0] fill_data_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(WB_DEPTH) + 1;

    state_t                r_state;
    logic [31:0]           r_miss_addr;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [31:0]           r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic                  w_active;
    logic                  w_load_miss;
    logic                  w_store;
    logic                  w_ack;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_store_stall;
    logic                  w_more;
    wb_entry_t             w_push_entry;
    wb_entry_t             w_head;
    wb_entry_t             w_next;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;

    assign w_active      = (r_state == S_IDLE) || (r_state == S_WRITE);
    assign w_load_miss   = rd_en_i && !hit_i && w_active;
    // A store presented together with a load is dropped.
    assign w_store       = wr_en_i && !rd_en_i && w_active;
    assign w_ack         = r_mem_req && mem_ack_i;
    assign w_pop         = w_ack && ((r_state == S_WRITE) || (r_state == S_DRAIN));
    assign w_push        = w_store && (!w_full || w_pop) && !rst_i;
    assign w_store_stall = w_store && w_full && !w_pop;
    // Another entry sits behind the head, so the next write can go out back-to-back.
    assign w_more        = (w_count > CNT_W'(1));
    assign w_push_entry  = {addr_i, wdata_i};

    dcache_write_buffer #(
        .DEPTH (WB_DEPTH)
    ) u_wb (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_entry (w_push_entry),
        .o_head  (w_head),
        .o_next  (w_next),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign stall_o = !rst_i && ((r_state == S_DRAIN) || (r_state == S_READ) ||
                                w_load_miss || w_store_stall);

    always_comb begin
        fill_en_o   = 1'b0;
        fill_addr_o = '0;
        fill_data_o = '0;
        if (r_state == S_FILL) begin
            fill_en_o   = 1'b1;
            fill_addr_o = r_miss_addr;
            fill_data_o = r_rdata;
        end else if (w_push && hit_i) begin
            fill_en_o   = 1'b1;
            fill_addr_o = addr_i;
            fill_data_o = wdata_i;
        end
    end

    assign rdata_o       = r_rdata;
    assign rdata_valid_o = (r_state == S_FILL);
    assign mem_req_o     = r_mem_req;
    assign mem_we_o      = r_mem_we;
    assign mem_addr_o    = r_mem_addr;
    assign mem_wdata_o   = r_mem_wdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_miss_addr <= '0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load_miss) begin
                        r_miss_addr <= addr_i;
                        r_mem_req   <= 1'b1;
                        if (w_empty) begin
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= addr_i;
                            r_state    <= S_READ;
                        end else begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= w_head.addr;
                            r_mem_wdata <= w_head.data;
                            r_state     <= S_DRAIN;
                        end
                    end else if (!w_empty) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= w_head.addr;
                        r_mem_wdata <= w_head.data;
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_load_miss) begin
                        r_miss_addr <= addr_i;
                        r_state     <= S_DRAIN;
                        if (w_ack && w_more) begin
                            r_mem_addr  <= w_next.addr;
                            r_mem_wdata <= w_next.data;
                        end else if (w_ack) begin
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= addr_i;
                            r_state    <= S_READ;
                        end
                    end else if (w_ack) begin
                        if (w_more) begin
                            r_mem_addr  <= w_next.addr;
                            r_mem_wdata <= w_next.data;
                        end else begin
                            r_mem_req <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_ack) begin
                        if (w_more) begin
                            r_mem_addr  <= w_next.addr;
                            r_mem_wdata <= w_next.data;
                        end else begin
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= r_miss_addr;
                            r_state    <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (w_ack) begin
                        r_rdata   <= mem_rdata_i;
                        r_mem_req <= 1'b0;
                        r_state   <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl with a behavioural multi-cycle memory.
module tb_dcache_miss_ctrl;

    logic        clk = 1'b0;
    logic        rst_i, rd_en_i, wr_en_i, hit_i, mem_ack_i;
    logic [31:0] addr_i, wdata_i, mem_rdata_i;
    logic        stall_o, rdata_valid_o, fill_en_o, mem_req_o, mem_we_o;
    logic [31:0] rdata_o, fill_addr_o, fill_data_o, mem_addr_o, mem_wdata_o;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int mem_lat = 1;
    bit inject_ack = 1'b0;

    logic [31:0] mem_data [256];
    bit          mem_valid [256];
    logic        log_we [64];
    logic [31:0] log_addr [64];
    logic [31:0] log_data [64];
    int          log_start [64];
    int          log_ack [64];
    int          log_n = 0;
    int          fill_total = 0;
    int          stall_total = 0;

    always #5 clk = ~clk;

    dcache_miss_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .rd_en_i       (rd_en_i),
        .wr_en_i       (wr_en_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .hit_i         (hit_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .fill_en_o     (fill_en_o),
        .fill_addr_o   (fill_addr_o),
        .fill_data_o   (fill_data_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Contents of never-written memory words.
    function automatic logic [31:0] bg_word(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : ~a;
    endfunction

    // Memory: acks mem_lat cycles after a request is first seen.
    int          m_cnt = 0;
    int          m_start = 0;
    logic [7:0]  m_idx;
    always @(posedge clk) begin
        #2;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        m_idx       = mem_addr_o[9:2];
        if (rst_i === 1'b1) begin
            m_cnt = 0;
        end else if (mem_req_o === 1'b1) begin
            m_cnt++;
            if (m_cnt == 1) m_start = cyc;
            if (m_cnt == mem_lat + 1) begin
                mem_ack_i = 1'b1;
                if (mem_we_o) begin
                    mem_data[m_idx]  = mem_wdata_o;
                    mem_valid[m_idx] = 1'b1;
                end else begin
                    mem_rdata_i = mem_valid[m_idx] ? mem_data[m_idx] : bg_word(mem_addr_o);
                end
                if (log_n < 64) begin
                    log_we[log_n]    = mem_we_o;
                    log_addr[log_n]  = mem_addr_o;
                    log_data[log_n]  = mem_we_o ? mem_wdata_o : mem_rdata_i;
                    log_start[log_n] = m_start;
                    log_ack[log_n]   = cyc;
                    log_n++;
                end
                m_cnt = 0;
            end
        end else begin
            m_cnt = 0;
        end
        if (inject_ack) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'hBAD0BAD0;
        end
    end

    always @(negedge clk) begin
        if (fill_en_o === 1'b1) fill_total++;
        if (stall_o === 1'b1) stall_total++;
        assert (!(rd_en_i === 1'b1 && wr_en_i === 1'b1))
            else $error("protocol violation: rd_en_i and wr_en_i together");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Waits for three consecutive quiet cycles (no request, no stall).
    task automatic settle;
        int quiet = 0;
        int k = 0;
        while (quiet < 3 && k < 200) begin
            @(negedge clk);
            k++;
            if (!mem_req_o && !stall_o) quiet++; else quiet = 0;
        end
        n_total++;
        if (quiet < 3) $display("FAIL settle_timeout: got busy after %0d cycles, required idle", k);
        else n_pass++;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic h,
                            output int stalls, output logic fe,
                            output logic [31:0] fa, output logic [31:0] fd);
        rd_en_i = 1'b0; wr_en_i = 1'b1; addr_i = a; wdata_i = d; hit_i = h;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!stall_o) break;
            stalls++;
            if (stalls > 60) begin
                n_total++;
                $display("FAIL store_timeout: got stall for %0d cycles at %h, required accept", stalls, a);
                break;
            end
        end
        fe = fill_en_o; fa = fill_addr_o; fd = fill_data_o;
        tick;
        wr_en_i = 1'b0; hit_i = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, output int stalls,
                           output logic [31:0] rd, output logic rv, output logic fe,
                           output logic [31:0] fa, output logic [31:0] fd);
        rd_en_i = 1'b1; wr_en_i = 1'b0; addr_i = a; hit_i = 1'b0;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!stall_o) break;
            stalls++;
            if (stalls > 60) begin
                n_total++;
                $display("FAIL load_timeout: got stall for %0d cycles at %h, required fill", stalls, a);
                break;
            end
        end
        rd = rdata_o; rv = rdata_valid_o; fe = fill_en_o; fa = fill_addr_o; fd = fill_data_o;
        tick;
        rd_en_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (3) tick;
        @(negedge clk);
        n_total++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b required 0", stall_o); else n_pass++;
        n_total++; if (mem_req_o !== 1'b0) $display("FAIL reset_req: got %b required 0", mem_req_o); else n_pass++;
        n_total++; if (mem_we_o !== 1'b0) $display("FAIL reset_we: got %b required 0", mem_we_o); else n_pass++;
        n_total++; if (mem_addr_o !== 32'h0) $display("FAIL reset_addr: got %h required 0", mem_addr_o); else n_pass++;
        n_total++; if (fill_en_o !== 1'b0) $display("FAIL reset_fill: got %b required 0", fill_en_o); else n_pass++;
        n_total++; if (rdata_valid_o !== 1'b0) $display("FAIL reset_rvalid: got %b required 0", rdata_valid_o); else n_pass++;
        n_total++; if (rdata_o !== 32'h0) $display("FAIL reset_rdata: got %h required 0", rdata_o); else n_pass++;
        tick;
        rst_i = 1'b0;
        @(negedge clk);
        n_total++; if (mem_req_o !== 1'b0) $display("FAIL post_reset_req: got %b required 0", mem_req_o); else n_pass++;
        $display("reset: done");
    endtask

    task automatic test_load_miss;
        int s, b;
        logic [31:0] rd, fa, fd;
        logic rv, fe;
        mem_lat = 3;
        b = log_n;
        tick;
        do_load(32'h40, s, rd, rv, fe, fa, fd);
        n_total++; if (s != 5) $display("FAIL miss_stall_cycles: got %0d required 5", s); else n_pass++;
        n_total++; if (rv !== 1'b1) $display("FAIL miss_rvalid: got %b required 1", rv); else n_pass++;
        n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL miss_rdata: got %h required deadbeef", rd); else n_pass++;
        n_total++; if (fe !== 1'b1) $display("FAIL miss_fill_en: got %b required 1", fe); else n_pass++;
        n_total++; if (fa !== 32'h40) $display("FAIL miss_fill_addr: got %h required 40", fa); else n_pass++;
        n_total++; if (fd !== 32'hDEADBEEF) $display("FAIL miss_fill_data: got %h required deadbeef", fd); else n_pass++;
        settle;
        n_total++; if (log_n - b != 1) $display("FAIL miss_req_count: got %0d required 1", log_n - b); else n_pass++;
        n_total++; if (log_we[b] !== 1'b0 || log_addr[b] !== 32'h40)
            $display("FAIL miss_req: got we=%b addr=%h required we=0 addr=40", log_we[b], log_addr[b]); else n_pass++;
        $display("load_miss: addr=40 stall=%0d rdata=%h", s, rd);
    endtask

    task automatic test_store_order;
        int s0, s1, s2, b, f0;
        logic fe0, fe1, fe2;
        logic [31:0] fa, fd;
        logic [31:0] exp_a [3];
        mem_lat = 2;
        b = log_n; f0 = fill_total;
        exp_a[0] = 32'h10; exp_a[1] = 32'h14; exp_a[2] = 32'h18;
        tick;
        do_store(32'h10, 32'hA0000010, 1'b0, s0, fe0, fa, fd);
        do_store(32'h14, 32'hA0000014, 1'b0, s1, fe1, fa, fd);
        do_store(32'h18, 32'hA0000018, 1'b0, s2, fe2, fa, fd);
        n_total++; if (s0 != 0 || s1 != 0) $display("FAIL order_first_stalls: got %0d,%0d required 0,0", s0, s1); else n_pass++;
        n_total++; if (s2 != 2) $display("FAIL order_third_stall: got %0d required 2", s2); else n_pass++;
        settle;
        n_total++; if (log_n - b != 3) $display("FAIL order_write_count: got %0d required 3", log_n - b); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (log_we[b+k] !== 1'b1 || log_addr[b+k] !== exp_a[k] || log_data[b+k] !== (32'hA0000000 | exp_a[k]))
                $display("FAIL order_write%0d: got we=%b addr=%h data=%h required we=1 addr=%h", k,
                         log_we[b+k], log_addr[b+k], log_data[b+k], exp_a[k]);
            else n_pass++;
        end
        n_total++; if (fill_total - f0 != 0 || fe0 || fe1 || fe2)
            $display("FAIL order_no_fill: got %0d fills required 0", fill_total - f0); else n_pass++;
        $display("store_order: stalls=%0d,%0d,%0d writes=%0d", s0, s1, s2, log_n - b);
    endtask

    task automatic test_store_hit;
        int s, b, st0;
        logic fe;
        logic [31:0] fa, fd;
        mem_lat = 3;
        b = log_n; st0 = stall_total;
        tick;
        do_store(32'h20, 32'h1234, 1'b1, s, fe, fa, fd);
        n_total++; if (fe !== 1'b1) $display("FAIL hit_fill_en: got %b required 1", fe); else n_pass++;
        n_total++; if (fa !== 32'h20 || fd !== 32'h1234)
            $display("FAIL hit_fill: got %h/%h required 20/1234", fa, fd); else n_pass++;
        settle;
        n_total++; if (stall_total - st0 != 0) $display("FAIL hit_no_stall: got %0d required 0", stall_total - st0); else n_pass++;
        n_total++; if (log_n - b != 1 || log_we[b] !== 1'b1 || log_addr[b] !== 32'h20 || log_data[b] !== 32'h1234)
            $display("FAIL hit_write: got n=%0d addr=%h data=%h required 1 20 1234", log_n - b, log_addr[b], log_data[b]);
        else n_pass++;
        $display("store_hit: addr=20 data=1234 fill=%b", fe);
    endtask

    task automatic test_raw;
        int s0, s, b;
        logic fe0, rv, fe;
        logic [31:0] rd, fa, fd;
        mem_lat = 2;
        b = log_n;
        tick;
        do_store(32'h30, 32'h5, 1'b0, s0, fe0, fa, fd);
        do_load(32'h30, s, rd, rv, fe, fa, fd);
        n_total++; if (s != 7) $display("FAIL raw_stall_cycles: got %0d required 7", s); else n_pass++;
        n_total++; if (rd !== 32'h5 || fa !== 32'h30) $display("FAIL raw_rdata: got %h@%h required 5@30", rd, fa); else n_pass++;
        settle;
        n_total++; if (log_n - b != 2 || log_we[b] !== 1'b1 || log_we[b+1] !== 1'b0 || log_addr[b+1] !== 32'h30)
            $display("FAIL raw_sequence: got n=%0d we=%b,%b required write then read", log_n - b, log_we[b], log_we[b+1]);
        else n_pass++;
        n_total++; if (!(log_ack[b] < log_start[b+1]))
            $display("FAIL raw_order: got write ack %0d read req %0d required ack first", log_ack[b], log_start[b+1]);
        else n_pass++;
        $display("raw: store 30=5 then load 30 -> %h stall=%0d", rd, s);
    endtask

    task automatic test_back_to_back;
        int s, b;
        logic fe;
        logic [31:0] fa, fd;
        mem_lat = 1;
        b = log_n;
        tick;
        for (int k = 0; k < 4; k++) begin
            do_store(32'h50 + 32'(4*k), 32'hC0 + 32'(k), 1'b0, s, fe, fa, fd);
        end
        settle;
        n_total++; if (log_n - b != 4) $display("FAIL b2b_count: got %0d required 4", log_n - b); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (log_addr[b+k] !== 32'h50 + 32'(4*k) || log_data[b+k] !== 32'hC0 + 32'(k))
                $display("FAIL b2b_write%0d: got %h=%h required %h=%h", k, log_addr[b+k], log_data[b+k],
                         32'h50 + 32'(4*k), 32'hC0 + 32'(k));
            else n_pass++;
        end
        for (int k = 1; k < 4; k++) begin
            n_total++;
            if (log_start[b+k] != log_ack[b+k-1] + 1)
                $display("FAIL b2b_gap%0d: got req at %0d prev ack %0d required back-to-back", k,
                         log_start[b+k], log_ack[b+k-1]);
            else n_pass++;
        end
        $display("back_to_back: %0d writes first_req=%0d last_ack=%0d", log_n - b, log_start[b], log_ack[b+3]);
    endtask

    task automatic test_reset_mid;
        int b, f0, reqs, s;
        logic fe;
        logic [31:0] fa, fd;
        mem_lat = 6;
        b = log_n;
        tick;
        rd_en_i = 1'b1; hit_i = 1'b0; addr_i = 32'h60;
        repeat (3) @(negedge clk);
        n_total++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0)
            $display("FAIL rst_read_pending: got req=%b we=%b required 1 0", mem_req_o, mem_we_o); else n_pass++;
        tick;
        rst_i = 1'b1; rd_en_i = 1'b0;
        tick;
        rst_i = 1'b0;
        @(negedge clk);
        n_total++; if (mem_req_o !== 1'b0) $display("FAIL rst_read_req: got %b required 0", mem_req_o); else n_pass++;
        n_total++; if (stall_o !== 1'b0) $display("FAIL rst_read_stall: got %b required 0", stall_o); else n_pass++;
        f0 = fill_total;
        tick;
        inject_ack = 1'b1;
        tick;
        inject_ack = 1'b0;
        repeat (5) @(negedge clk);
        n_total++; if (fill_total - f0 != 0 || rdata_o !== 32'h0)
            $display("FAIL rst_late_ack: got fills=%0d rdata=%h required 0 0", fill_total - f0, rdata_o); else n_pass++;
        n_total++; if (log_n - b != 0) $display("FAIL rst_read_logged: got %0d required 0", log_n - b); else n_pass++;
        $display("reset_mid_read: req=%b stall=%b", mem_req_o, stall_o);

        mem_lat = 8;
        tick;
        do_store(32'h70, 32'h77, 1'b0, s, fe, fa, fd);
        do_store(32'h74, 32'h78, 1'b0, s, fe, fa, fd);
        @(negedge clk);
        n_total++; if (mem_req_o !== 1'b1) $display("FAIL rst_write_pending: got %b required 1", mem_req_o); else n_pass++;
        tick;
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        reqs = 0;
        repeat (12) begin
            @(negedge clk);
            if (mem_req_o) reqs++;
        end
        n_total++; if (reqs != 0 || log_n - b != 0)
            $display("FAIL rst_buffer_discard: got %0d req cycles %0d writes required 0 0", reqs, log_n - b); else n_pass++;
        settle;
        $display("reset_mid_write: req_cycles_after=%0d", reqs);
    endtask

    initial begin
        rst_i = 1'b1; rd_en_i = 1'b0; wr_en_i = 1'b0; hit_i = 1'b0;
        addr_i = 32'h0; wdata_i = 32'h0;
        test_reset;
        test_load_miss;
        test_store_order;
        test_store_hit;
        test_raw;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
